// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode encoding, default widths
// and small opcode classification helpers.
package decode_pkg;

    localparam int INSTR_W_DEF = 32;
    localparam int OPC_W_DEF   = 4;
    localparam int VREG_W_DEF  = 1;
    localparam int IMM_W_DEF   = 25;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [3:0] {
        OPC_INCRI = 4'd0,
        OPC_INCRJ = 4'd1,
        OPC_SETN  = 4'd2,
        OPC_SUMFV = 4'd3,
        OPC_MULFV = 4'd4,
        OPC_NOP   = 4'd5,
        OPC_LDV   = 4'd6
    } opcode_e;

    localparam int OPC_LAST_LEGAL = 6;

    // True for the opcodes that operate on vector registers.
    function automatic logic is_vec_op(input logic [31:0] opc);
        return (opc == 32'(OPC_SUMFV)) || (opc == 32'(OPC_MULFV)) ||
               (opc == 32'(OPC_LDV));
    endfunction

    // Everything above LDV in the opcode space is reserved.
    function automatic logic is_legal_op(input logic [31:0] opc);
        return opc <= 32'(OPC_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/decode_stage_loop_counters.sv
// N/I/J loop counter bank. SETN loads the loop bound and restarts both
// iterators; INCRI/INCRJ advance their iterator and wrap at the bound.
module loop_counters
    import decode_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_en,
    input  logic             op_setn,
    input  logic             op_incri,
    input  logic             op_incrj,
    input  logic [CNT_W-1:0] set_val,
    output logic [CNT_W-1:0] n_o,
    output logic [CNT_W-1:0] i_o,
    output logic [CNT_W-1:0] j_o
);

    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] i_q, i_d;
    logic [CNT_W-1:0] j_q, j_d;

    // Advance an iterator, wrapping to zero when it would reach the bound.
    // A zero bound pins the iterator at zero. The extra bit keeps the
    // increment from overflowing before the compare.
    function automatic logic [CNT_W-1:0] step(input logic [CNT_W-1:0] cur,
                                              input logic [CNT_W-1:0] lim);
        logic [CNT_W:0] nxt;
        nxt = {1'b0, cur} + {{CNT_W{1'b0}}, 1'b1};
        if (lim == '0) begin
            return '0;
        end else if (nxt == {1'b0, lim}) begin
            return '0;
        end else begin
            return nxt[CNT_W-1:0];
        end
    endfunction

    // Next-state for the counters; nothing moves unless an instruction is accepted.
    always_comb begin
        n_d = n_q;
        i_d = i_q;
        j_d = j_q;
        if (upd_en) begin
            if (op_setn) begin
                n_d = set_val;
                i_d = '0;
                j_d = '0;
            end else if (op_incri) begin
                i_d = step(i_q, n_q);
            end else if (op_incrj) begin
                j_d = step(j_q, n_q);
            end
        end
    end

    // Counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q <= '0;
            i_q <= '0;
            j_q <= '0;
        end else begin
            n_q <= n_d;
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign n_o = n_q;
    assign i_o = i_q;
    assign j_o = j_q;

endmodule

// File: rtl/decode_stage.sv
// Single-entry decode pipeline stage with loop counters.
// Optional feature macro DECODE_ILLEGAL_TRAP_EN: when defined, an illegal
// opcode raises a sticky illegal_o and blocks the stage until reset; when
// undefined, illegal opcodes are passed downstream as NOP.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OPC_W   = OPC_W_DEF,
    parameter int VREG_W  = VREG_W_DEF,
    parameter int IMM_W   = IMM_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPC_W-1:0]  opcode_o,
    output logic [VREG_W-1:0] vdst_o,
    output logic [VREG_W-1:0] vsrc_o,
    output logic [IMM_W-1:0]  imm_o,
    output logic              vec_op_o,
    output logic [CNT_W-1:0]  n_o,
    output logic [CNT_W-1:0]  i_o,
    output logic [CNT_W-1:0]  j_o,
    output logic              illegal_o
);

    logic [OPC_W-1:0]  opc_f;
    logic [VREG_W-1:0] vdst_f;
    logic [VREG_W-1:0] vsrc_f;
    logic [IMM_W-1:0]  imm_f;
    logic              legal;
    logic              accept;
    logic              forward;
    logic              blocked;

    logic              out_valid_q, out_valid_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [VREG_W-1:0] vdst_q, vdst_d;
    logic [VREG_W-1:0] vsrc_q, vsrc_d;
    logic [IMM_W-1:0]  imm_q, imm_d;
    logic              vec_op_q, vec_op_d;

    // Slice the raw instruction into its fields and classify the opcode.
    always_comb begin
        opc_f  = instr[INSTR_W-1 -: OPC_W];
        vdst_f = instr[INSTR_W-OPC_W-1 -: VREG_W];
        vsrc_f = instr[INSTR_W-OPC_W-VREG_W-1 -: VREG_W];
        imm_f  = instr[IMM_W-1:0];
        legal  = is_legal_op(32'(opc_f));
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    // Sticky trap: once an illegal opcode is taken, the stage stops accepting.
    always_comb begin
        illegal_d = illegal_q || (accept && !legal);
    end

    // Trap flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign blocked   = illegal_q;
    assign forward   = accept && legal;
    assign illegal_o = illegal_q;
`else
    assign blocked   = 1'b0;
    assign forward   = accept;
    assign illegal_o = 1'b0;
`endif

    assign in_ready = !blocked && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Pipeline register next-state: load on a forwarded accept, drain when
    // downstream takes the entry, otherwise hold the fields steady.
    always_comb begin
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        vdst_d      = vdst_q;
        vsrc_d      = vsrc_q;
        imm_d       = imm_q;
        vec_op_d    = vec_op_q;
        if (forward) begin
            out_valid_d = 1'b1;
            opcode_d    = legal ? opc_f : OPC_W'(OPC_NOP);
            vdst_d      = vdst_f;
            vsrc_d      = vsrc_f;
            imm_d       = imm_f;
            vec_op_d    = legal && is_vec_op(32'(opc_f));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output entry register; reset aborts any held entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            vdst_q      <= '0;
            vsrc_q      <= '0;
            imm_q       <= '0;
            vec_op_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            vdst_q      <= vdst_d;
            vsrc_q      <= vsrc_d;
            imm_q       <= imm_d;
            vec_op_q    <= vec_op_d;
        end
    end

    assign out_valid = out_valid_q;
    assign opcode_o  = opcode_q;
    assign vdst_o    = vdst_q;
    assign vsrc_o    = vsrc_q;
    assign imm_o     = imm_q;
    assign vec_op_o  = vec_op_q;

    // Counters only see legal accepted instructions; illegal ones never
    // touch loop state even when passed on as NOP.
    loop_counters #(
        .CNT_W (CNT_W)
    ) u_loop_counters (
        .clk      (clk),
        .rst_n    (rst_n),
        .upd_en   (accept && legal),
        .op_setn  (opc_f == OPC_W'(OPC_SETN)),
        .op_incri (opc_f == OPC_W'(OPC_INCRI)),
        .op_incrj (opc_f == OPC_W'(OPC_INCRJ)),
        .set_val  (CNT_W'(imm_f)),
        .n_o      (n_o),
        .i_o      (i_o),
        .j_o      (j_o)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: a table of single-cycle vectors
// followed by hand-written stall, illegal-opcode and async-reset sequences.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode_o;
    logic [0:0]  vdst_o;
    logic [0:0]  vsrc_o;
    logic [24:0] imm_o;
    logic        vec_op_o;
    logic [15:0] n_o;
    logic [15:0] i_o;
    logic [15:0] j_o;
    logic        illegal_o;

    int vectors;
    int miscompares;

    decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode_o  (opcode_o),
        .vdst_o    (vdst_o),
        .vsrc_o    (vsrc_o),
        .imm_o     (imm_o),
        .vec_op_o  (vec_op_o),
        .n_o       (n_o),
        .i_o       (i_o),
        .j_o       (j_o),
        .illegal_o (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  opc;
        logic        vdst;
        logic        vsrc;
        logic [24:0] imm;
        logic        vec;
        logic [15:0] n;
        logic [15:0] i;
        logic [15:0] j;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [31:0] mk_instr(input logic [3:0] opc, input logic vd,
                                             input logic vs, input logic [24:0] imm);
        return {opc, vd, vs, 1'b0, imm};
    endfunction

    function automatic vec_t mkv(input logic [3:0] opc, input logic vd, input logic vs,
                                 input logic [24:0] imm, input logic vec,
                                 input logic [15:0] n, input logic [15:0] i,
                                 input logic [15:0] j);
        vec_t v;
        v.opc = opc; v.vdst = vd; v.vsrc = vs; v.imm = imm;
        v.vec = vec; v.n = n; v.i = i; v.j = j;
        return v;
    endfunction

    task automatic applyStimulus(input logic [31:0] ins, input logic v, input logic r);
        @(negedge clk);
        instr     = ins;
        in_valid  = v;
        out_ready = r;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Counter walk: SETN 400 and increments, SETN 2 wrap, vector ops,
        // SETN truncation (0x10003 -> 3), then a zero bound.
        tbl[0]  = mkv(4'd2, 1'b0, 1'b0, 25'd400,      1'b0, 16'd400, 16'd0, 16'd0);
        tbl[1]  = mkv(4'd0, 1'b0, 1'b0, 25'd0,        1'b0, 16'd400, 16'd1, 16'd0);
        tbl[2]  = mkv(4'd0, 1'b0, 1'b0, 25'd0,        1'b0, 16'd400, 16'd2, 16'd0);
        tbl[3]  = mkv(4'd0, 1'b0, 1'b0, 25'd0,        1'b0, 16'd400, 16'd3, 16'd0);
        tbl[4]  = mkv(4'd1, 1'b0, 1'b0, 25'd0,        1'b0, 16'd400, 16'd3, 16'd1);
        tbl[5]  = mkv(4'd2, 1'b0, 1'b0, 25'd2,        1'b0, 16'd2,   16'd0, 16'd0);
        tbl[6]  = mkv(4'd0, 1'b0, 1'b0, 25'd0,        1'b0, 16'd2,   16'd1, 16'd0);
        tbl[7]  = mkv(4'd0, 1'b0, 1'b0, 25'd0,        1'b0, 16'd2,   16'd0, 16'd0);
        tbl[8]  = mkv(4'd0, 1'b0, 1'b0, 25'd0,        1'b0, 16'd2,   16'd1, 16'd0);
        tbl[9]  = mkv(4'd1, 1'b0, 1'b0, 25'd0,        1'b0, 16'd2,   16'd1, 16'd1);
        tbl[10] = mkv(4'd1, 1'b0, 1'b0, 25'd0,        1'b0, 16'd2,   16'd1, 16'd0);
        tbl[11] = mkv(4'd3, 1'b1, 1'b1, 25'h1ABCDEF,  1'b1, 16'd2,   16'd1, 16'd0);
        tbl[12] = mkv(4'd6, 1'b0, 1'b1, 25'd0,        1'b1, 16'd2,   16'd1, 16'd0);
        tbl[13] = mkv(4'd5, 1'b1, 1'b0, 25'h1FFFFFF,  1'b0, 16'd2,   16'd1, 16'd0);
        tbl[14] = mkv(4'd2, 1'b0, 1'b0, 25'h10003,    1'b0, 16'd3,   16'd0, 16'd0);
        tbl[15] = mkv(4'd2, 1'b0, 1'b0, 25'd0,        1'b0, 16'd0,   16'd0, 16'd0);
        tbl[16] = mkv(4'd0, 1'b0, 1'b0, 25'd0,        1'b0, 16'd0,   16'd0, 16'd0);
        tbl[17] = mkv(4'd1, 1'b0, 1'b0, 25'd0,        1'b0, 16'd0,   16'd0, 16'd0);

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        instr       = '0;

        // Reset state.
        #12;
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_n_o",       32'(n_o),       32'd0);
        checkOutput("rst_illegal",   32'(illegal_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table vectors with downstream always ready.
        for (int k = 0; k < 18; k++) begin
            applyStimulus(mk_instr(tbl[k].opc, tbl[k].vdst, tbl[k].vsrc, tbl[k].imm),
                          1'b1, 1'b1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("v%0d_opcode", k),    32'(opcode_o),  32'(tbl[k].opc));
            checkOutput($sformatf("v%0d_vdst", k),      32'(vdst_o),    32'(tbl[k].vdst));
            checkOutput($sformatf("v%0d_vsrc", k),      32'(vsrc_o),    32'(tbl[k].vsrc));
            checkOutput($sformatf("v%0d_imm", k),       32'(imm_o),     32'(tbl[k].imm));
            checkOutput($sformatf("v%0d_vec_op", k),    32'(vec_op_o),  32'(tbl[k].vec));
            checkOutput($sformatf("v%0d_n", k),         32'(n_o),       32'(tbl[k].n));
            checkOutput($sformatf("v%0d_i", k),         32'(i_o),       32'(tbl[k].i));
            checkOutput($sformatf("v%0d_j", k),         32'(j_o),       32'(tbl[k].j));
        end

        // Backpressure: MULFV held for three cycles while INCRI waits.
        applyStimulus(mk_instr(4'd2, 1'b0, 1'b0, 25'd5), 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("stall_setn_n", 32'(n_o), 32'd5);
        applyStimulus(mk_instr(4'd4, 1'b1, 1'b0, 25'h123), 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("stall_mulfv_valid", 32'(out_valid), 32'd1);
        applyStimulus(mk_instr(4'd0, 1'b0, 1'b0, 25'd0), 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall%0d_valid", c),  32'(out_valid), 32'd1);
            checkOutput($sformatf("stall%0d_opcode", c), 32'(opcode_o),  32'd4);
            checkOutput($sformatf("stall%0d_vdst", c),   32'(vdst_o),    32'd1);
            checkOutput($sformatf("stall%0d_vsrc", c),   32'(vsrc_o),    32'd0);
            checkOutput($sformatf("stall%0d_imm", c),    32'(imm_o),     32'h123);
            checkOutput($sformatf("stall%0d_vec_op", c), 32'(vec_op_o),  32'd1);
            checkOutput($sformatf("stall%0d_i", c),      32'(i_o),       32'd0);
            if (c < 2) @(negedge clk);
        end
        applyStimulus(mk_instr(4'd0, 1'b0, 1'b0, 25'd0), 1'b1, 1'b1);
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("release_valid",  32'(out_valid), 32'd1);
        checkOutput("release_opcode", 32'(opcode_o),  32'd0);
        checkOutput("release_vec_op", 32'(vec_op_o),  32'd0);
        checkOutput("release_i",      32'(i_o),       32'd1);
        applyStimulus('0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("drain_valid", 32'(out_valid), 32'd0);

        // Illegal opcode 0xF.
        applyStimulus(mk_instr(4'hF, 1'b0, 1'b0, 25'd7), 1'b1, 1'b1);
        @(posedge clk);
        #1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        checkOutput("trap_illegal",   32'(illegal_o), 32'd1);
        checkOutput("trap_out_valid", 32'(out_valid), 32'd0);
        checkOutput("trap_in_ready",  32'(in_ready),  32'd0);
        applyStimulus(mk_instr(4'd2, 1'b0, 1'b0, 25'd9), 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("trap_hold_illegal",  32'(illegal_o), 32'd1);
        checkOutput("trap_hold_in_ready", 32'(in_ready),  32'd0);
        checkOutput("trap_hold_n",        32'(n_o),       32'd5);
        checkOutput("trap_hold_valid",    32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("trap_rst_illegal", 32'(illegal_o), 32'd0);
        checkOutput("trap_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
`else
        checkOutput("illegal_valid",  32'(out_valid), 32'd1);
        checkOutput("illegal_opcode", 32'(opcode_o),  32'd5);
        checkOutput("illegal_flag",   32'(illegal_o), 32'd0);
        checkOutput("illegal_vec_op", 32'(vec_op_o),  32'd0);
        checkOutput("illegal_n",      32'(n_o),       32'd5);
        checkOutput("illegal_i",      32'(i_o),       32'd1);
        checkOutput("illegal_in_ready", 32'(in_ready), 32'd1);
`endif

        // Asynchronous reset while an entry is held and n=400.
        applyStimulus(mk_instr(4'd2, 1'b0, 1'b0, 25'd400), 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("ar_n_before", 32'(n_o), 32'd400);
        applyStimulus('0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("ar_valid_before", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid",    32'(out_valid), 32'd0);
        checkOutput("ar_n",        32'(n_o),       32'd0);
        checkOutput("ar_opcode",   32'(opcode_o),  32'd0);
        checkOutput("ar_imm",      32'(imm_o),     32'd0);
        checkOutput("ar_in_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready),  32'd1);
        checkOutput("post_rst_valid",    32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
